// File: rtl/mul_unit_pipe.sv
// mul_unit_pipe: 3-stage pipelined signed multiplier with valid/ready flow
// control and a per-beat approx mode that drops the A_lo*B_lo partial product.
// Sign-magnitude core: S1 captures sign and magnitudes, S2 forms four
// half-width partial products, S3 sums them and restores the sign.
// Optional feature macro: MUL_UNIT_PIPE_STATS_EN adds the 32-bit op_count port
// (accepted-beat counter, wraps, cleared by reset).
// W must be even and >= 4.
module mul_unit_pipe #(
  parameter int W = 16
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
`ifdef MUL_UNIT_PIPE_STATS_EN
  ,
  output logic [31:0]    op_count
`endif
);

  localparam int H = W / 2;
  localparam logic [W-1:0]   ONE_W  = 1;
  localparam logic [2*W-1:0] ONE_2W = 1;

  // stage valid bits, index = stage number
  logic [3:1] vld_q, vld_d;
  logic [3:1] en;
  logic       accept;

  // S1 registers
  logic         sign1_q, sign1_d;
  logic [W-1:0] maga1_q, maga1_d;
  logic [W-1:0] magb1_q, magb1_d;
  logic         approx1_q;

  // S2 registers
  logic         sign2_q;
  logic [W-1:0] hh2_q, hl2_q, lh2_q, ll2_q;
  logic [W-1:0] hh2_d, hl2_d, lh2_d, ll2_d;

  // S3 register
  logic [2*W-1:0] p3_q, p3_d;
  logic [2*W:0]   sum_w;
  logic [2*W-1:0] m_w;

  // Stage enables: a stage may load when it is empty or its content moves on.
  // in_ready chains combinationally from the output so a full pipe still
  // accepts a beat in the cycle its oldest result is taken.
  always_comb begin
    en[3]    = !vld_q[3] | out_ready;
    en[2]    = !vld_q[2] | en[3];
    en[1]    = !vld_q[1] | en[2];
    in_ready = en[1];
    accept   = in_valid & en[1];
    vld_d[1] = en[1] ? accept   : vld_q[1];
    vld_d[2] = en[2] ? vld_q[1] : vld_q[2];
    vld_d[3] = en[3] ? vld_q[2] : vld_q[3];
  end

  // S1 next state: product sign and W-bit operand magnitudes (-2^(W-1) maps to 2^(W-1))
  always_comb begin
    sign1_d = in_a[W-1] ^ in_b[W-1];
    maga1_d = in_a[W-1] ? (~in_a + ONE_W) : in_a;
    magb1_d = in_b[W-1] ? (~in_b + ONE_W) : in_b;
  end

  // S2 next state: four exact half-width partial products, zero-extended to W bits
  always_comb begin
    hh2_d = {{H{1'b0}}, maga1_q[W-1:H]} * {{H{1'b0}}, magb1_q[W-1:H]};
    hl2_d = {{H{1'b0}}, maga1_q[W-1:H]} * {{H{1'b0}}, magb1_q[H-1:0]};
    lh2_d = {{H{1'b0}}, maga1_q[H-1:0]} * {{H{1'b0}}, magb1_q[W-1:H]};
    ll2_d = approx1_q ? '0
                      : {{H{1'b0}}, maga1_q[H-1:0]} * {{H{1'b0}}, magb1_q[H-1:0]};
  end

  // S3 next state: align and sum partials in 2W+1 bits, then apply the sign
  always_comb begin
    sum_w = {1'b0, hh2_q, {W{1'b0}}}
          + {{(W-H){1'b0}}, ({1'b0, hl2_q} + {1'b0, lh2_q}), {H{1'b0}}}
          + {{(W+1){1'b0}}, ll2_q};
    m_w   = sum_w[2*W-1:0];
    p3_d  = sign2_q ? (~m_w + ONE_2W) : m_w;
  end

  // Control state and output register; out_p only loads with a real beat so
  // it holds during stalls and stays deterministic across bubbles.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      vld_q <= '0;
      p3_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (en[3] && vld_q[2]) p3_q <= p3_d;
    end
  end

  // Datapath registers: no reset needed, qualified by the valid bits
  always_ff @(posedge nvdla_core_clk) begin
    if (accept) begin
      sign1_q   <= sign1_d;
      maga1_q   <= maga1_d;
      magb1_q   <= magb1_d;
      approx1_q <= in_approx;
    end
    if (en[2] && vld_q[1]) begin
      sign2_q <= sign1_q;
      hh2_q   <= hh2_d;
      hl2_q   <= hl2_d;
      lh2_q   <= lh2_d;
      ll2_q   <= ll2_d;
    end
  end

  assign out_valid = vld_q[3];
  assign out_p     = p3_q;

`ifdef MUL_UNIT_PIPE_STATS_EN
  logic [31:0] op_count_q;

  // Accepted-beat counter, wraps naturally at 2^32
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) op_count_q <= '0;
    else if (accept)    op_count_q <= op_count_q + 32'd1;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mul_unit_pipe.sv
module tb_mul_unit_pipe;

  localparam int TW = 16;
  localparam int TH = TW / 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a, in_b;
  logic          in_approx;
  logic          out_valid;
  logic          out_ready;
  logic [2*TW-1:0] out_p;
`ifdef MUL_UNIT_PIPE_STATS_EN
  logic [31:0]   op_count;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  mul_unit_pipe #(.W(TW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_approx      (in_approx),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_p          (out_p)
`ifdef MUL_UNIT_PIPE_STATS_EN
    ,
    .op_count       (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_p(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                        input logic ap);
    longint sa, sb, ma, mb, ll, prod;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    prod = sa * sb;
    if (ap) begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      ll = (ma % (longint'(1) << TH)) * (mb % (longint'(1) << TH));
      if ((sa < 0) != (sb < 0)) prod = prod + ll;
      else                      prod = prod - ll;
    end
    return prod[31:0];
  endfunction

  localparam int ND = 12;
  logic [TW-1:0] da [ND];
  logic [TW-1:0] db [ND];
  logic          dx [ND];
  logic [31:0]   de [ND];

  logic [TW-1:0] ra [100];
  logic [TW-1:0] rb [100];
  logic          rx [100];
  logic [31:0]   re [100];

  logic [TW-1:0] ba [5];
  logic [TW-1:0] bb [5];
  logic [31:0]   be [5];

  initial begin
    int k;
    da[0]  = 16'd3;     db[0]  = 16'hFFFB; dx[0]  = 0; de[0]  = 32'hFFFFFFF1;
    da[1]  = 16'h8000;  db[1]  = 16'h8000; dx[1]  = 0; de[1]  = 32'h40000000;
    da[2]  = 16'h0101;  db[2]  = 16'h0101; dx[2]  = 1; de[2]  = 32'h00010200;
    da[3]  = 16'h0101;  db[3]  = 16'h0101; dx[3]  = 0; de[3]  = 32'h00010201;
    da[4]  = 16'hFEFF;  db[4]  = 16'h0101; dx[4]  = 1; de[4]  = 32'hFFFEFE00;
    da[5]  = 16'h0000;  db[5]  = 16'hFFF9; dx[5]  = 0; de[5]  = 32'h00000000;
    da[6]  = 16'h0000;  db[6]  = 16'hFFF9; dx[6]  = 1; de[6]  = 32'h00000000;
    da[7]  = 16'h7FFF;  db[7]  = 16'h7FFF; dx[7]  = 0; de[7]  = 32'h3FFF0001;
    da[8]  = 16'h7FFF;  db[8]  = 16'h7FFF; dx[8]  = 1; de[8]  = 32'h3FFE0200;
    da[9]  = 16'h8000;  db[9]  = 16'h0001; dx[9]  = 0; de[9]  = 32'hFFFF8000;
    da[10] = 16'hFFFF;  db[10] = 16'hFFFF; dx[10] = 1; de[10] = 32'h00000000;
    da[11] = 16'hFFFF;  db[11] = 16'hFFFF; dx[11] = 0; de[11] = 32'h00000001;

    for (int i = 0; i < 100; i++) begin
      ra[i] = TW'($urandom);
      rb[i] = TW'($urandom);
      rx[i] = 1'($urandom_range(0, 1));
      re[i] = ref_p(ra[i], rb[i], rx[i]);
    end
    for (int i = 0; i < 5; i++) begin
      ba[i] = TW'(16'h0100 * (i + 1) + 3);
      bb[i] = TW'(16'hFFF0 - i);
      be[i] = ref_p(ba[i], bb[i], 1'b0);
    end

    rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_approx = 0; out_ready = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    for (int c = 0; c < ND + 3; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) chk("dir_latency_valid", out_valid, 1'b0);
      if (c >= 3) begin
        chk("dir_valid", out_valid, 1'b1);
        chk("dir_p", out_p, de[c-3]);
      end
      if (c < ND) begin
        in_valid = 1; in_a = da[c]; in_b = db[c]; in_approx = dx[c];
      end else in_valid = 0;
    end
    @(negedge clk);
    chk("dir_drain_valid", out_valid, 1'b0);

    for (int c = 0; c < 103; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        chk("str_valid", out_valid, 1'b1);
        chk("str_p", out_p, re[c-3]);
      end
      if (c < 100) begin
        in_valid = 1; in_a = ra[c]; in_b = rb[c]; in_approx = rx[c];
      end else in_valid = 0;
      #1;
      chk("str_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    chk("str_drain_valid", out_valid, 1'b0);

    k = 0;
    in_approx = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (k < 5) begin
        in_valid = 1; in_a = ba[k]; in_b = bb[k];
      end else in_valid = 0;
      #1;
      chk("bp_in_ready", in_ready, (c == 3 || c == 4) ? 1'b0 : 1'b1);
      if (c == 3 || c == 4) begin
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_p", out_p, be[0]);
      end
      if (c >= 5 && c <= 9) begin
        chk("bp_rel_valid", out_valid, 1'b1);
        chk("bp_rel_p", out_p, be[c-5]);
      end
      if (c == 10) chk("bp_drain_valid", out_valid, 1'b0);
      if (in_valid && in_ready) k++;
    end
    chk("bp_accepted", k, 5);

    out_ready = 1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      rst = 0; in_valid = 0;
      if (c < 2) begin
        in_valid = 1; in_a = da[c]; in_b = db[c]; in_approx = 0;
      end
      if (c == 2) rst = 1;
      if (c == 3) begin
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_p", out_p, 32'h0);
        in_valid = 1; in_a = da[7]; in_b = db[7]; in_approx = 0;
      end
      if (c == 4 || c == 5) chk("mrst_gap_valid", out_valid, 1'b0);
      if (c == 6) begin
        chk("mrst_next_valid", out_valid, 1'b1);
        chk("mrst_next_p", out_p, de[7]);
      end
    end

`ifdef MUL_UNIT_PIPE_STATS_EN
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("cnt_reset", op_count, 32'd0);
    for (int c = 0; c < 7; c++) begin
      in_valid = 1; in_a = da[c]; in_b = db[c];
      @(negedge clk);
    end
    in_valid = 0;
    chk("cnt_seven", op_count, 32'd7);
    force dut.op_count_q = 32'hFFFFFFFF;
    #1;
    release dut.op_count_q;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_a = da[c]; in_b = db[c];
      @(negedge clk);
    end
    in_valid = 0;
    chk("cnt_wrap", op_count, 32'd2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("cnt_clear", op_count, 32'd0);
`endif

    in_valid = 0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
